// File: rtl/i2c_sensor_sequencer_if.sv
// i2c_sensor_sequencer_if: command/response link between the sensor sequencer and the I2C byte master
interface i2c_sensor_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready, rsp_valid, rsp_data, rsp_nack);
  modport slave (input cmd_valid, cmd_op, cmd_data, output cmd_ready, rsp_valid, rsp_data, rsp_nack);
endinterface

// File: rtl/i2c_sensor_sequencer.sv
// i2c_sensor_sequencer: configures the gyro over I2C, then burst-reads three axes on every sample tick
module i2c_sensor_sequencer #(
  parameter logic [6:0] DEV_ADDR   = 7'h68,
  parameter logic [7:0] CFG_REG0   = 8'h6B,
  parameter logic [7:0] CFG_VAL0   = 8'h00,
  parameter logic [7:0] CFG_REG1   = 8'h1B,
  parameter logic [7:0] CFG_VAL1   = 8'h18,
  parameter logic [7:0] DATA_REG   = 8'h43,
  parameter int         SAMPLE_DIV = 500000,
  parameter int         MAX_RETRY  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          restart,
  i2c_sensor_sequencer_if.master        bus,
  output logic [15:0]                   gyro_x,
  output logic [15:0]                   gyro_y,
  output logic [15:0]                   gyro_z,
  output logic                          sample_valid,
  output logic                          init_done,
  output logic                          busy,
  output logic                          fault,
  output logic                          overrun
);
  localparam logic [2:0] OP_START = 3'd0, OP_WRITE = 3'd1, OP_RACK = 3'd2, OP_RNACK = 3'd3, OP_STOP = 3'd4;
  localparam logic [31:0] CNT_LAST = 32'(SAMPLE_DIV - 1);
  localparam logic [7:0] RETRY_LAST = 8'(MAX_RETRY - 1);
  typedef enum logic [2:0] {CFG0, CFG1, IDLE, READ, FAULT} state_t;
  state_t      state_q;
  logic [3:0]  step_q;
  logic        out_q, active_q, abort_q, pending_q;
  logic [7:0]  retry_q;
  logic [31:0] cnt_q;
  logic [47:0] shadow_q;
  logic        wrap, start_xfer, last_step;
  function automatic logic [10:0] cmd_at(input state_t st, input logic [3:0] s);
    if (st == READ)
      return (s == 4'd0 || s == 4'd3) ? {OP_START, 8'h00} :
             s == 4'd1  ? {OP_WRITE, DEV_ADDR, 1'b0} :
             s == 4'd2  ? {OP_WRITE, DATA_REG} :
             s == 4'd4  ? {OP_WRITE, DEV_ADDR, 1'b1} :
             s < 4'd10  ? {OP_RACK, 8'h00} :
             s == 4'd10 ? {OP_RNACK, 8'h00} : {OP_STOP, 8'h00};
    return s == 4'd0 ? {OP_START, 8'h00} :
           s == 4'd1 ? {OP_WRITE, DEV_ADDR, 1'b0} :
           s == 4'd2 ? {OP_WRITE, st == CFG0 ? CFG_REG0 : CFG_REG1} :
           s == 4'd3 ? {OP_WRITE, st == CFG0 ? CFG_VAL0 : CFG_VAL1} : {OP_STOP, 8'h00};
  endfunction
  assign wrap       = cnt_q == CNT_LAST;
  assign start_xfer = bus.cmd_valid && bus.cmd_ready && state_q == READ && step_q == 4'd0;
  assign last_step  = step_q == (state_q == READ ? 4'd11 : 4'd4);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CFG0;
      step_q        <= '0;
      out_q         <= 1'b0;
      active_q      <= 1'b0;
      abort_q       <= 1'b0;
      pending_q     <= 1'b0;
      retry_q       <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_op    <= '0;
      bus.cmd_data  <= '0;
      gyro_x        <= '0;
      gyro_y        <= '0;
      gyro_z        <= '0;
      sample_valid  <= 1'b0;
      init_done     <= 1'b0;
      busy          <= 1'b0;
      fault         <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      cnt_q        <= wrap ? '0 : cnt_q + 32'd1;
      pending_q    <= wrap || (pending_q && !start_xfer);
      if (wrap && pending_q) overrun <= 1'b1;
      if (bus.cmd_valid && bus.cmd_ready) begin
        bus.cmd_valid <= 1'b0;
        out_q         <= 1'b1;
        busy          <= 1'b1;
      end else if (out_q && bus.rsp_valid) begin
        out_q <= 1'b0;
        if (abort_q) begin
          abort_q <= 1'b0;
          if (retry_q == RETRY_LAST) begin
            state_q  <= FAULT;
            fault    <= 1'b1;
            busy     <= 1'b0;
            active_q <= 1'b0;
          end else begin
            retry_q                     <= retry_q + 8'd1;
            step_q                      <= '0;
            bus.cmd_valid               <= 1'b1;
            {bus.cmd_op, bus.cmd_data}  <= cmd_at(state_q, 4'd0);
          end
        end else if (bus.cmd_op == OP_WRITE && bus.rsp_nack) begin
          abort_q                    <= 1'b1;
          shadow_q                   <= '0;
          bus.cmd_valid              <= 1'b1;
          {bus.cmd_op, bus.cmd_data} <= {OP_STOP, 8'h00};
        end else if (last_step) begin
          retry_q  <= '0;
          busy     <= 1'b0;
          active_q <= 1'b0;
          state_q  <= state_q == CFG0 ? CFG1 : IDLE;
          if (state_q == CFG1) init_done <= 1'b1;
          if (state_q == READ) begin
            {gyro_x, gyro_y, gyro_z} <= shadow_q;
            sample_valid             <= 1'b1;
          end
        end else begin
          if (bus.cmd_op == OP_RACK || bus.cmd_op == OP_RNACK) shadow_q <= {shadow_q[39:0], bus.rsp_data};
          step_q                     <= step_q + 4'd1;
          bus.cmd_valid              <= 1'b1;
          {bus.cmd_op, bus.cmd_data} <= cmd_at(state_q, step_q + 4'd1);
        end
      end else if (!active_q && (state_q == CFG0 || state_q == CFG1 || state_q == READ)) begin
        active_q                   <= 1'b1;
        step_q                     <= '0;
        bus.cmd_valid              <= 1'b1;
        {bus.cmd_op, bus.cmd_data} <= cmd_at(state_q, 4'd0);
      end else if (state_q == IDLE && pending_q) begin
        state_q <= READ;
      end else if (state_q == FAULT && restart) begin
        state_q   <= CFG0;
        fault     <= 1'b0;
        retry_q   <= '0;
        init_done <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2c_sensor_sequencer.sv
// tb_i2c_sensor_sequencer: byte-master model with transaction-level reference checks for the gyro sequencer
module tb_i2c_sensor_sequencer;
  localparam int DIV = 100;
  logic clk = 1'b0, rst = 1'b1, restart = 1'b0;
  logic [15:0] gyro_x, gyro_y, gyro_z;
  logic sample_valid, init_done, busy, fault, overrun;
  i2c_sensor_sequencer_if bus();
  i2c_sensor_sequencer #(.SAMPLE_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .restart(restart), .bus(bus),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .sample_valid(sample_valid), .init_done(init_done), .busy(busy), .fault(fault), .overrun(overrun)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [0:5][7:0] b;
    logic [15:0] x, y, z;
  } vec_t;
  vec_t tbl[4];
  int total = 0, bad = 0, proto_err = 0, nack_addr = 0;
  bit hold_ready = 1'b0, nack_all = 1'b0;
  logic [10:0] log_q[$], exp_q[$];
  logic [7:0] rd_q[$];
  logic [0:5][7:0] rb;
  logic [10:0] op0;
  int stable, seen, i;
  initial begin : byte_master
    bit outst;
    int lat;
    logic [2:0] op_o;
    logic [7:0] d_o;
    outst = 1'b0; lat = 0; op_o = '0; d_o = '0;
    bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0; bus.rsp_nack = 1'b0;
    forever begin
      @(negedge clk);
      bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_nack = 1'b0; bus.rsp_data = '0;
      if (rst) outst = 1'b0;
      else if (outst) begin
        if (bus.cmd_valid) proto_err++;
        if (lat > 0) lat--;
        else begin
          outst = 1'b0;
          bus.rsp_valid = 1'b1;
          if (op_o == 3'd1) begin
            bus.rsp_nack = nack_all || (nack_addr > 0 && d_o == 8'hD0);
            if (!nack_all && nack_addr > 0 && d_o == 8'hD0) nack_addr--;
          end else if (op_o == 3'd2 || op_o == 3'd3)
            bus.rsp_data = rd_q.size() > 0 ? rd_q.pop_front() : 8'($urandom);
        end
      end else if (bus.cmd_valid && !hold_ready && $urandom_range(0, 2) != 0) begin
        bus.cmd_ready = 1'b1;
        outst = 1'b1;
        lat = int'($urandom_range(0, 1));
        op_o = bus.cmd_op;
        d_o = bus.cmd_data;
        log_q.push_back({op_o, d_o});
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic e(input logic [2:0] op, input logic [7:0] d);
    exp_q.push_back({op, d});
  endtask
  task automatic exp_cfg(input logic [7:0] r, input logic [7:0] v);
    e(3'd0, 8'h00); e(3'd1, 8'hD0); e(3'd1, r); e(3'd1, v); e(3'd4, 8'h00);
  endtask
  task automatic exp_read();
    e(3'd0, 8'h00); e(3'd1, 8'hD0); e(3'd1, 8'h43); e(3'd0, 8'h00); e(3'd1, 8'hD1);
    for (int k = 0; k < 5; k++) e(3'd2, 8'h00);
    e(3'd3, 8'h00); e(3'd4, 8'h00);
  endtask
  task automatic exp_abort();
    e(3'd0, 8'h00); e(3'd1, 8'hD0); e(3'd4, 8'h00);
  endtask
  task automatic exp_init();
    exp_cfg(8'h6B, 8'h00); exp_cfg(8'h1B, 8'h18);
  endtask
  task automatic chk_log(input string name);
    int d;
    d = -1;
    for (int k = 0; k < log_q.size() && k < exp_q.size(); k++)
      if (d < 0 && log_q[k] !== exp_q[k]) d = k;
    if (d < 0 && log_q.size() != exp_q.size()) d = log_q.size() < exp_q.size() ? log_q.size() : exp_q.size();
    total++;
    if (d >= 0) begin
      bad++;
      $display("FAIL %s: got %0d cmds want %0d, first diff at %0d got %h want %h", name, log_q.size(), exp_q.size(), d,
               d < log_q.size() ? log_q[d] : 11'h7FF, d < exp_q.size() ? exp_q[d] : 11'h7FF);
    end
    log_q.delete();
    exp_q.delete();
  endtask
  task automatic push_bytes(input logic [0:5][7:0] b);
    for (int k = 0; k < 6; k++) rd_q.push_back(b[k]);
  endtask
  task automatic wait_for(input int which, input int budget, input string name);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((which == 0 && init_done) || (which == 1 && sample_valid) || (which == 2 && fault) || (which == 3 && bus.cmd_valid)) break;
    end
    total++;
    if (n == budget) begin
      bad++;
      $display("FAIL %s: got timeout after %0d cycles want event", name, budget);
    end
  endtask
  task automatic chk_gyro(input string name, input logic [0:5][7:0] b);
    chk({name, "_x"}, 64'(gyro_x), 64'({b[0], b[1]}));
    chk({name, "_y"}, 64'(gyro_y), 64'({b[2], b[3]}));
    chk({name, "_z"}, 64'(gyro_z), 64'({b[4], b[5]}));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    log_q.delete();
    rd_q.delete();
    rst = 1'b0;
  endtask
  initial begin
    tbl[0] = '{{8'h12, 8'h34, 8'hFF, 8'hFE, 8'h80, 8'h00}, 16'h1234, 16'hFFFE, 16'h8000};
    tbl[1] = '{{8'h7F, 8'hFF, 8'h80, 8'h01, 8'h00, 8'h00}, 16'h7FFF, 16'h8001, 16'h0000};
    tbl[2] = '{{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hA5, 8'h5A}, 16'h0001, 16'hFFFF, 16'hA55A};
    tbl[3] = '{{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h7F, 8'hFF}, 16'hFFFF, 16'h0000, 16'h7FFF};
    repeat (3) @(negedge clk);
    chk("reset_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    chk("reset_flags", 64'({init_done, busy, fault, overrun, sample_valid}), 64'd0);
    chk("reset_gyro", 64'({gyro_x, gyro_y, gyro_z}), 64'd0);
    push_bytes(tbl[0].b);
    rst = 1'b0;
    wait_for(0, 300, "init");
    exp_init();
    chk_log("cfg_stream");
    chk("init_gyro", 64'({gyro_x, gyro_y, gyro_z}), 64'd0);
    chk("init_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) push_bytes(tbl[k].b);
      wait_for(1, 300, "table_sample");
      chk("table_x", 64'(gyro_x), 64'(tbl[k].x));
      chk("table_y", 64'(gyro_y), 64'(tbl[k].y));
      chk("table_z", 64'(gyro_z), 64'(tbl[k].z));
      chk("table_busy", 64'(busy), 64'd0);
      exp_read();
      chk_log("table_read_stream");
      @(negedge clk);
      chk("sample_pulse_width", 64'(sample_valid), 64'd0);
    end
    for (int k = 0; k < 6; k++) begin
      rb = {$urandom(), 16'($urandom())};
      push_bytes(rb);
      wait_for(1, 300, "rand_sample");
      chk_gyro("rand", rb);
      exp_read();
      chk_log("rand_read_stream");
    end
    chk("no_overrun", 64'(overrun), 64'd0);
    chk("no_fault", 64'(fault), 64'd0);
    nack_addr = 1;
    rb = {$urandom(), 16'($urandom())};
    push_bytes(rb);
    wait_for(1, 400, "nack_once_sample");
    exp_abort(); exp_read();
    chk_log("nack_once_stream");
    chk_gyro("nack_once", rb);
    chk("nack_once_fault", 64'(fault), 64'd0);
    nack_addr = 2;
    rb = {$urandom(), 16'($urandom())};
    push_bytes(rb);
    wait_for(1, 400, "nack_twice_sample");
    exp_abort(); exp_abort(); exp_read();
    chk_log("nack_twice_stream");
    chk_gyro("nack_twice", rb);
    chk("nack_twice_fault", 64'(fault), 64'd0);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_ignored_init", 64'(init_done), 64'd1);
    chk("restart_ignored_fault", 64'(fault), 64'd0);
    nack_all = 1'b1;
    do_reset();
    wait_for(2, 300, "fault");
    exp_abort(); exp_abort(); exp_abort();
    chk_log("fault_stream");
    chk("fault_busy", 64'(busy), 64'd0);
    chk("fault_init", 64'(init_done), 64'd0);
    seen = 0;
    repeat (2 * DIV) begin
      @(negedge clk);
      if (bus.cmd_valid) seen++;
    end
    chk("fault_quiet", 64'(seen), 64'd0);
    chk("fault_sticky", 64'(fault), 64'd1);
    chk("fault_overrun", 64'(overrun), 64'd1);
    nack_all = 1'b0;
    push_bytes(tbl[0].b);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_clears_fault", 64'(fault), 64'd0);
    wait_for(0, 300, "reinit");
    exp_init();
    chk_log("reinit_stream");
    wait_for(1, 300, "reinit_sample");
    chk_gyro("reinit", tbl[0].b);
    exp_read();
    chk_log("reinit_read_stream");
    chk("overrun_sticky", 64'(overrun), 64'd1);
    do_reset();
    wait_for(0, 300, "hold_init");
    exp_init();
    chk_log("hold_cfg_stream");
    hold_ready = 1'b1;
    wait_for(3, 300, "hold_valid");
    op0 = {bus.cmd_op, bus.cmd_data};
    stable = 0;
    repeat (2 * DIV + 10) begin
      @(negedge clk);
      if (!bus.cmd_valid || {bus.cmd_op, bus.cmd_data} !== op0) stable++;
    end
    chk("hold_stable", 64'(stable), 64'd0);
    chk("hold_op_start", 64'(op0), 64'd0);
    chk("hold_busy", 64'(busy), 64'd0);
    chk("hold_overrun", 64'(overrun), 64'd1);
    rb = {$urandom(), 16'($urandom())};
    push_bytes(rb);
    hold_ready = 1'b0;
    wait_for(1, 300, "hold_sample");
    exp_read();
    chk_log("hold_one_read");
    chk_gyro("hold", rb);
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (log_q.size() >= 8) break;
    end
    chk("midread_reached", 64'(i < 300), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midread_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    chk("midread_busy", 64'(busy), 64'd0);
    chk("midread_init", 64'(init_done), 64'd0);
    chk("midread_gyro", 64'({gyro_x, gyro_y, gyro_z}), 64'd0);
    do_reset();
    wait_for(0, 300, "midread_reinit");
    exp_init();
    chk_log("midread_cfg_stream");
    chk("protocol", 64'(proto_err), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
